// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: MEM-stage exception flags in, CP0 exception strobe and pipeline redirect out.
interface exc_ctrl_if;
  logic        stall_i;
  logic        inst_valid_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic        adel_if_i;
  logic        ri_i;
  logic        syscall_i;
  logic        break_i;
  logic        ov_i;
  logic        adel_mem_i;
  logic        ades_mem_i;
  logic        eret_i;
  logic [31:0] mem_addr_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] newpc_o;
  modport master (
    output stall_i, inst_valid_i, pc_i, is_in_delayslot_i, adel_if_i, ri_i, syscall_i, break_i,
           ov_i, adel_mem_i, ades_mem_i, eret_i, mem_addr_i, status_i, cause_i, epc_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, flush_o, newpc_o
  );
  modport slave (
    input  stall_i, inst_valid_i, pc_i, is_in_delayslot_i, adel_if_i, ri_i, syscall_i, break_i,
           ov_i, adel_mem_i, ades_mem_i, eret_i, mem_addr_i, status_i, cause_i, epc_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, flush_o, newpc_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception prioritiser; holds the selected exception across stalls and issues a one-cycle CP0 strobe with flush/redirect.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic       clk,
  input  logic       resetn,
  exc_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PEND, ISSUE} state_t;
  state_t      state, state_nx;
  logic        int_req, sync_flag, det, go;
  logic [31:0] code, bad;
  logic [31:0] cap_code, cap_pc, cap_bad;
  logic        cap_ds;
  logic [31:0] sel_code, sel_pc, sel_bad;
  logic        sel_ds;
  logic        unused;
  assign unused = ^{bus.cause_i[31:16], bus.cause_i[7:0], bus.status_i[31:16], bus.status_i[7:2]};
  assign int_req   = bus.status_i[0] & ~bus.status_i[1] & |(bus.cause_i[15:8] & bus.status_i[15:8]);
  assign sync_flag = |{bus.adel_if_i, bus.ri_i, bus.syscall_i, bus.break_i, bus.ov_i,
                       bus.adel_mem_i, bus.ades_mem_i, bus.eret_i};
  assign det       = bus.inst_valid_i & (int_req | sync_flag);
  assign code = int_req        ? 32'h1 :
                bus.adel_if_i  ? 32'h4 :
                bus.ri_i       ? 32'hA :
                bus.syscall_i  ? 32'h8 :
                bus.break_i    ? 32'h9 :
                bus.ov_i       ? 32'hC :
                bus.adel_mem_i ? 32'h4 :
                bus.ades_mem_i ? 32'h5 :
                bus.eret_i     ? 32'hE : 32'h0;
  // BadVAddr only for the address error that actually won priority
  assign bad  = int_req ? 32'h0 :
                bus.adel_if_i ? bus.pc_i :
                (bus.ri_i | bus.syscall_i | bus.break_i | bus.ov_i) ? 32'h0 :
                (bus.adel_mem_i | bus.ades_mem_i) ? bus.mem_addr_i : 32'h0;
  assign sel_code = (state == PEND) ? cap_code : code;
  assign sel_pc   = (state == PEND) ? cap_pc   : bus.pc_i;
  assign sel_ds   = (state == PEND) ? cap_ds   : bus.is_in_delayslot_i;
  assign sel_bad  = (state == PEND) ? cap_bad  : bad;
  assign go       = (state_nx == ISSUE);
  always_comb begin
    state_nx = state;
    if (state == IDLE && det) state_nx = bus.stall_i ? PEND : ISSUE;
    else if (state == PEND && !bus.stall_i) state_nx = ISSUE;
    else if (state == ISSUE) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                   <= IDLE;
      cap_code                <= '0;
      cap_pc                  <= '0;
      cap_ds                  <= 1'b0;
      cap_bad                 <= '0;
      bus.excepttype_o        <= '0;
      bus.current_inst_addr_o <= '0;
      bus.is_in_delayslot_o   <= 1'b0;
      bus.bad_addr_o          <= '0;
      bus.flush_o             <= 1'b0;
      bus.newpc_o             <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && det) begin
        cap_code <= code;
        cap_pc   <= bus.pc_i;
        cap_ds   <= bus.is_in_delayslot_i;
        cap_bad  <= bad;
      end
      bus.excepttype_o <= go ? sel_code : 32'h0;
      bus.flush_o      <= go;
      bus.newpc_o      <= go ? ((sel_code == 32'hE) ? bus.epc_i : EXC_VECTOR) : 32'h0;
      if (go) begin
        bus.current_inst_addr_o <= sel_pc;
        bus.is_in_delayslot_o   <= sel_ds;
        bus.bad_addr_o          <= sel_bad;
      end
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed vectors with hand-computed expectations for exc_ctrl.
module tb_exc_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exc_ctrl_if ifc();
  exc_ctrl #(.EXC_VECTOR(32'hBFC00380)) dut (.clk(clk), .resetn(resetn), .bus(ifc));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    ifc.stall_i = 0; ifc.inst_valid_i = 0; ifc.pc_i = 0; ifc.is_in_delayslot_i = 0;
    ifc.adel_if_i = 0; ifc.ri_i = 0; ifc.syscall_i = 0; ifc.break_i = 0; ifc.ov_i = 0;
    ifc.adel_mem_i = 0; ifc.ades_mem_i = 0; ifc.eret_i = 0; ifc.mem_addr_i = 0;
    ifc.status_i = 0; ifc.cause_i = 0; ifc.epc_i = 0;
  endtask
  initial begin
    clr();
    ifc.inst_valid_i = 1; ifc.ov_i = 1; ifc.pc_i = 32'h1111_0000;
    step(); step();
    chk("rst_exc", ifc.excepttype_o, 0);
    chk("rst_flush", {31'd0, ifc.flush_o}, 0);
    chk("rst_newpc", ifc.newpc_o, 0);
    chk("rst_addr", ifc.current_inst_addr_o, 0);
    chk("rst_bad", ifc.bad_addr_o, 0);
    chk("rst_ds", {31'd0, ifc.is_in_delayslot_o}, 0);
    resetn = 1; clr(); step();
    // overflow, no stall
    ifc.inst_valid_i = 1; ifc.ov_i = 1; ifc.pc_i = 32'hBFC00100;
    step(); clr();
    chk("ov_exc", ifc.excepttype_o, 32'hC);
    chk("ov_addr", ifc.current_inst_addr_o, 32'hBFC00100);
    chk("ov_flush", {31'd0, ifc.flush_o}, 1);
    chk("ov_newpc", ifc.newpc_o, 32'hBFC00380);
    chk("ov_bad", ifc.bad_addr_o, 0);
    step();
    chk("ov_flush_off", {31'd0, ifc.flush_o}, 0);
    chk("ov_exc_off", ifc.excepttype_o, 0);
    chk("ov_newpc_off", ifc.newpc_o, 0);
    chk("ov_addr_hold", ifc.current_inst_addr_o, 32'hBFC00100);
    // load address error held across a 3-cycle stall
    ifc.inst_valid_i = 1; ifc.adel_mem_i = 1; ifc.mem_addr_i = 32'h80000003;
    ifc.pc_i = 32'hBFC00200; ifc.stall_i = 1;
    step();
    chk("adel_stall1", {31'd0, ifc.flush_o}, 0);
    ifc.pc_i = 32'h0000_1234; ifc.ri_i = 1; ifc.mem_addr_i = 0;
    ifc.status_i = 32'h0000FF01; ifc.cause_i = 32'h0000_0400;
    step();
    chk("adel_stall2", {31'd0, ifc.flush_o}, 0);
    step();
    chk("adel_stall3", ifc.excepttype_o, 0);
    clr();
    step();
    chk("adel_exc", ifc.excepttype_o, 32'h4);
    chk("adel_bad", ifc.bad_addr_o, 32'h80000003);
    chk("adel_addr", ifc.current_inst_addr_o, 32'hBFC00200);
    chk("adel_flush", {31'd0, ifc.flush_o}, 1);
    step();
    chk("adel_done", {31'd0, ifc.flush_o}, 0);
    // interrupt pre-empts syscall
    ifc.inst_valid_i = 1; ifc.syscall_i = 1; ifc.pc_i = 32'hBFC00300;
    ifc.status_i = 32'h0000FF01; ifc.cause_i = 32'h0000_0400;
    step(); clr();
    chk("int_exc", ifc.excepttype_o, 32'h1);
    chk("int_newpc", ifc.newpc_o, 32'hBFC00380);
    step();
    // interrupt masked by EXL, then by a bubble
    ifc.inst_valid_i = 1; ifc.status_i = 32'h0000FF03; ifc.cause_i = 32'h0000_0400;
    step();
    chk("int_exl_mask", {31'd0, ifc.flush_o}, 0);
    ifc.inst_valid_i = 0; ifc.status_i = 32'h0000FF01;
    step();
    chk("int_bubble", {31'd0, ifc.flush_o}, 0);
    chk("int_bubble_exc", ifc.excepttype_o, 0);
    ifc.status_i = 32'h0000FB01; ifc.inst_valid_i = 1;
    step();
    chk("int_im_mask", {31'd0, ifc.flush_o}, 0);
    clr();
    // eret in a delay slot
    ifc.inst_valid_i = 1; ifc.eret_i = 1; ifc.epc_i = 32'hBFC00480;
    ifc.is_in_delayslot_i = 1; ifc.pc_i = 32'hBFC00500;
    step(); clr();
    chk("eret_exc", ifc.excepttype_o, 32'hE);
    chk("eret_newpc", ifc.newpc_o, 32'hBFC00480);
    chk("eret_ds", {31'd0, ifc.is_in_delayslot_o}, 1);
    step();
    // eret through PEND takes EPC at the issuing edge
    ifc.inst_valid_i = 1; ifc.eret_i = 1; ifc.epc_i = 32'hBFC00480; ifc.stall_i = 1;
    step(); clr();
    ifc.epc_i = 32'hBFC00600;
    step();
    chk("eret_pend_newpc", ifc.newpc_o, 32'hBFC00600);
    chk("eret_pend_ds", {31'd0, ifc.is_in_delayslot_o}, 0);
    step();
    // fetch address error: BadVAddr is the PC
    ifc.inst_valid_i = 1; ifc.adel_if_i = 1; ifc.ov_i = 1; ifc.pc_i = 32'hBFC00005;
    step(); clr();
    chk("adelif_exc", ifc.excepttype_o, 32'h4);
    chk("adelif_bad", ifc.bad_addr_o, 32'hBFC00005);
    step();
    // priority among synchronous flags
    ifc.inst_valid_i = 1; ifc.ri_i = 1; ifc.syscall_i = 1; ifc.break_i = 1; ifc.ades_mem_i = 1;
    ifc.mem_addr_i = 32'h1234_5678;
    step(); clr();
    chk("prio_ri", ifc.excepttype_o, 32'hA);
    chk("prio_ri_bad", ifc.bad_addr_o, 0);
    step();
    ifc.inst_valid_i = 1; ifc.break_i = 1; ifc.ov_i = 1;
    step(); clr();
    chk("prio_break", ifc.excepttype_o, 32'h9);
    step();
    ifc.inst_valid_i = 1; ifc.ades_mem_i = 1; ifc.eret_i = 1; ifc.mem_addr_i = 32'h8000_0002;
    step(); clr();
    chk("prio_ades", ifc.excepttype_o, 32'h5);
    chk("prio_ades_bad", ifc.bad_addr_o, 32'h8000_0002);
    step();
    // back-to-back: ISSUE cycle ignores inputs
    ifc.inst_valid_i = 1; ifc.ov_i = 1; ifc.pc_i = 32'hBFC00700;
    step();
    chk("b2b_first", {31'd0, ifc.flush_o}, 1);
    ifc.pc_i = 32'hBFC00704;
    step();
    chk("b2b_gap", {31'd0, ifc.flush_o}, 0);
    ifc.pc_i = 32'hBFC00708;
    step(); clr();
    chk("b2b_second", {31'd0, ifc.flush_o}, 1);
    chk("b2b_addr", ifc.current_inst_addr_o, 32'hBFC00708);
    step();
    // reset while pending
    ifc.inst_valid_i = 1; ifc.ov_i = 1; ifc.pc_i = 32'hBFC00800; ifc.stall_i = 1;
    step();
    resetn = 0;
    step();
    chk("prst_exc", ifc.excepttype_o, 0);
    chk("prst_addr", ifc.current_inst_addr_o, 0);
    chk("prst_bad", ifc.bad_addr_o, 0);
    resetn = 1; clr();
    step();
    chk("prst_nostrobe1", {31'd0, ifc.flush_o}, 0);
    step();
    chk("prst_nostrobe2", {31'd0, ifc.flush_o}, 0);
    chk("prst_exc2", ifc.excepttype_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
